sim_ctrl_counter_chain: RTL and testbench



---
 rtl/sim_ctrl_counter_chain.sv | 166 ++++++++++++++++
 tb/tb_sim_ctrl_counter_chain.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sim_ctrl_counter_chain.sv
// sim_ctrl_counter_chain
//
// This block holds the simulation-control utilities that sit beside the
// manycore testbench core. A small host register port replaces the old
// DPI hooks.
//   - data chain   : data_i delayed by num_stages_p flops (0 = pass-through)
//   - cycle counter: free-running; its reset is held for num_stages_p extra
//                    cycles by a 1-bit chain fed from reset_i
//   - gpio         : host-writable register driving trace_en (bit0) and
//                    log_en (bit1)
//
// Ports
//   clk_i, reset_i        : single clock, synchronous active-high reset
//   data_i / data_o       : delay-chain input / output
//   ctr_r_o               : registered cycle count
//   gpio_i / gpio_o       : GPIO inputs / outputs
//   host_v_i, host_we_i   : request valid, 1 = write / 0 = read
//   host_addr_i           : register address (0..7)
//   host_wdata_i          : write data
//   host_rv_o             : read data valid, one cycle after the read is accepted
//   host_rdata_o          : read data; holds its last value when host_rv_o = 0
//
// Register map
//   0 gpio (rd: gpio_o or gpio_i per use_output_p, wr: gpio_o)
//   1 gpio_i (ro)
//   2 ctr[31:0] (rd also snapshots ctr[63:32] into the shadow)
//   3 shadow (ro)
//   4 control (wr bit0 = clear counter, reads 0)
//   5..7 reserved, read 0
module sim_ctrl_counter_chain #(
  parameter int unsigned              chain_width_p = 1,
  parameter int unsigned              num_stages_p  = 3,
  parameter int unsigned              ctr_width_p   = 64,
  parameter int unsigned              gpio_width_p  = 2,
  parameter logic [gpio_width_p-1:0]  init_o_p      = '0,
  parameter bit                       use_output_p  = 1'b1,
  parameter bit                       debug_p       = 1'b0
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [chain_width_p-1:0]  data_i,
  output logic [chain_width_p-1:0]  data_o,
  output logic [ctr_width_p-1:0]    ctr_r_o,
  input  logic [gpio_width_p-1:0]   gpio_i,
  output logic [gpio_width_p-1:0]   gpio_o,
  input  logic                      host_v_i,
  input  logic                      host_we_i,
  input  logic [2:0]                host_addr_i,
  input  logic [31:0]               host_wdata_i,
  output logic                      host_rv_o,
  output logic [31:0]               host_rdata_o
);

  // ---------------------------------------------------------------- data chain
  if (num_stages_p == 0) begin : g_data_pass
    assign data_o = data_i;
  end else begin : g_data_chain
    logic [chain_width_p-1:0] stage_r [num_stages_p];

    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        for (int unsigned k = 0; k < num_stages_p; k++) stage_r[k] <= '0;
      end else begin
        stage_r[0] <= data_i;
        for (int unsigned k = 1; k < num_stages_p; k++) stage_r[k] <= stage_r[k-1];
      end
    end

    assign data_o = stage_r[num_stages_p-1];
  end

  // ------------------------------------------------------ counter-reset chain
  logic rst_d;

  if (num_stages_p == 0) begin : g_rst_pass
    assign rst_d = reset_i;
  end else begin : g_rst_chain
    logic [num_stages_p-1:0] rchain_r;

    // Reset fills the chain with 1s. Afterwards 0s shift in from bit 0, so
    // the top bit stays high for num_stages_p more edges. Using a shift
    // instead of a slice keeps the single-stage case legal.
    always_ff @(posedge clk_i) begin
      if (reset_i) rchain_r <= '1;
      else         rchain_r <= rchain_r << 1;
    end

    assign rst_d = reset_i | rchain_r[num_stages_p-1];
  end

  // ------------------------------------------------------------ host decode
  logic rd_req, wr_req, clr_req;

  assign rd_req  = host_v_i & ~host_we_i;
  assign wr_req  = host_v_i &  host_we_i;
  assign clr_req = wr_req & (host_addr_i == 3'd4) & host_wdata_i[0];

  // ---------------------------------------------------------------- counter
  logic [ctr_width_p-1:0] ctr_r;
  logic [63:0]            ctr_ext;

  always_ff @(posedge clk_i) begin
    if (rst_d || clr_req) ctr_r <= '0;
    else                  ctr_r <= ctr_r + 1'b1;
  end

  assign ctr_r_o = ctr_r;
  // With the counter zero-extended to 64 bits, both the low-word read and
  // the shadow snapshot read 0 above ctr_width_p with no special cases.
  assign ctr_ext = 64'(ctr_r);

  // ------------------------------------------------------------------- gpio
  logic [gpio_width_p-1:0] gpio_next;

  always_comb begin
    gpio_next = gpio_o;
    if (reset_i)                                gpio_next = init_o_p;
    else if (wr_req && host_addr_i == 3'd0)     gpio_next = host_wdata_i[gpio_width_p-1:0];
  end

  always_ff @(posedge clk_i) begin
    gpio_o <= gpio_next;
  end

  if (debug_p) begin : g_debug
    // This print is for simulation only. It fires on a real value change,
    // so rewriting the same value stays silent.
    always_ff @(posedge clk_i) begin
      if (gpio_next != gpio_o) $display("%m: gpio_o 0x%0h -> 0x%0h", gpio_o, gpio_next);
    end
  end

  // -------------------------------------------------------------- read path
  logic [31:0] shadow_r;
  logic [31:0] rd_val;

  always_comb begin
    rd_val = '0;
    case (host_addr_i)
      3'd0:    rd_val = use_output_p ? 32'(gpio_o) : 32'(gpio_i);
      3'd1:    rd_val = 32'(gpio_i);
      3'd2:    rd_val = ctr_ext[31:0];
      3'd3:    rd_val = shadow_r;
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      shadow_r     <= '0;
      host_rv_o    <= 1'b0;
      host_rdata_o <= '0;
    end else begin
      host_rv_o <= rd_req;
      if (rd_req) begin
        host_rdata_o <= rd_val;
        if (host_addr_i == 3'd2) shadow_r <= ctr_ext[63:32];
      end
    end
  end

  // Only bit 0 and the gpio field of the write data have a meaning.
  logic unused_wdata;
  assign unused_wdata = ^host_wdata_i;

endmodule

// File: tb/tb_sim_ctrl_counter_chain.sv
module tb_sim_ctrl_counter_chain;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        v, we;
  logic [2:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  din;
  logic [1:0]  gpio_in;

  logic        d0;
  logic [63:0] c0;
  logic [1:0]  g0;
  logic        rv0;
  logic [31:0] rd0;

  logic [3:0]  d1;
  logic [3:0]  c1;
  logic [1:0]  g1;
  logic        rv1;
  logic [31:0] rd1;

  // Instance 0 uses the default configuration.
  sim_ctrl_counter_chain #(
    .chain_width_p(1), .num_stages_p(3), .ctr_width_p(64), .gpio_width_p(2),
    .init_o_p(2'b00), .use_output_p(1'b1), .debug_p(1'b0)
  ) u_dut (
    .clk_i(clk), .reset_i(reset), .data_i(din[0:0]), .data_o(d0), .ctr_r_o(c0),
    .gpio_i(gpio_in), .gpio_o(g0), .host_v_i(v), .host_we_i(we), .host_addr_i(addr),
    .host_wdata_i(wdata), .host_rv_o(rv0), .host_rdata_o(rd0)
  );

  // Instance 1: pass-through, 4-bit counter, reads of gpio return gpio_i.
  sim_ctrl_counter_chain #(
    .chain_width_p(4), .num_stages_p(0), .ctr_width_p(4), .gpio_width_p(2),
    .init_o_p(2'b01), .use_output_p(1'b0), .debug_p(1'b1)
  ) u_dut2 (
    .clk_i(clk), .reset_i(reset), .data_i(din), .data_o(d1), .ctr_r_o(c1),
    .gpio_i(gpio_in), .gpio_o(g1), .host_v_i(v), .host_we_i(we), .host_addr_i(addr),
    .host_wdata_i(wdata), .host_rv_o(rv1), .host_rdata_o(rd1)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------- behavioural model
  int unsigned ms_S     [2] = '{3, 0};
  int unsigned ms_W     [2] = '{64, 4};
  logic [3:0]  ms_dmask [2] = '{4'h1, 4'hF};
  bit          ms_useo  [2] = '{1'b1, 1'b0};
  logic [1:0]  ms_init  [2] = '{2'b00, 2'b01};

  logic [3:0]  m_hist   [2][8];   // m_hist[i][k] = data accepted k+1 edges ago
  int unsigned m_hold   [2];      // edges the counter must still read 0
  logic [63:0] m_ctr    [2];
  logic [31:0] m_shadow [2];
  logic [1:0]  m_gpio   [2];
  logic        m_rv     [2];
  logic [31:0] m_rdata  [2];
  bit          m_valid = 1'b0;

  function automatic logic [63:0] wmask(input int unsigned w);
    if (w >= 64) return '1;
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic logic [3:0] exp_data(input int i);
    if (ms_S[i] == 0) return din & ms_dmask[i];
    return m_hist[i][ms_S[i]-1];
  endfunction

  task automatic model_step(input int i);
    logic [31:0] rd;
    if (reset) begin
      for (int k = 0; k < 8; k++) m_hist[i][k] = '0;
      m_hold[i]   = ms_S[i];
      m_ctr[i]    = '0;
      m_shadow[i] = '0;
      m_gpio[i]   = ms_init[i];
      m_rv[i]     = 1'b0;
      m_rdata[i]  = '0;
    end else begin
      case (addr)
        3'd0:    rd = ms_useo[i] ? {30'd0, m_gpio[i]} : {30'd0, gpio_in};
        3'd1:    rd = {30'd0, gpio_in};
        3'd2:    rd = m_ctr[i][31:0];
        3'd3:    rd = m_shadow[i];
        default: rd = '0;
      endcase
      m_rv[i] = v && !we;
      if (v && !we) begin
        m_rdata[i] = rd;
        if (addr == 3'd2) m_shadow[i] = m_ctr[i][63:32];
      end
      if (v && we && addr == 3'd0) m_gpio[i] = wdata[1:0];
      if (m_hold[i] > 0) begin
        m_hold[i]--;
        m_ctr[i] = '0;
      end else if (v && we && addr == 3'd4 && wdata[0]) begin
        m_ctr[i] = '0;
      end else begin
        m_ctr[i] = (m_ctr[i] + 64'd1) & wmask(ms_W[i]);
      end
      for (int k = 7; k > 0; k--) m_hist[i][k] = m_hist[i][k-1];
      m_hist[i][0] = din & ms_dmask[i];
    end
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
    if (reset) m_valid = 1'b1;
  end

  // Compare process: every cycle once the model has seen a reset edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("u0.data_o",  64'(d0),  64'(exp_data(0)));
      check("u0.ctr_r_o", c0,       m_ctr[0]);
      check("u0.gpio_o",  64'(g0),  64'(m_gpio[0]));
      check("u0.rv",      64'(rv0), 64'(m_rv[0]));
      check("u0.rdata",   64'(rd0), 64'(m_rdata[0]));
      check("u1.data_o",  64'(d1),  64'(exp_data(1)));
      check("u1.ctr_r_o", 64'(c1),  m_ctr[1]);
      check("u1.gpio_o",  64'(g1),  64'(m_gpio[1]));
      check("u1.rv",      64'(rv1), 64'(m_rv[1]));
      check("u1.rdata",   64'(rd1), 64'(m_rdata[1]));
    end
  end

  // --------------------------------------------------------------- stimulus
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic iv, input logic iwe, input logic [2:0] ia, input logic [31:0] iw);
    v = iv; we = iwe; addr = ia; wdata = iw;
    tick();
    v = 1'b0; we = 1'b0; addr = '0; wdata = '0;
  endtask

  initial begin
    int guard;
    reset = 1'b1; v = 1'b0; we = 1'b0; addr = '0; wdata = '0; din = '0; gpio_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_data",   64'(d0),  64'd0);
    check("rst_ctr",    c0,       64'd0);
    check("rst_gpio0",  64'(g0),  64'd0);
    check("rst_gpio1",  64'(g1),  64'd1);
    check("rst_rv",     64'(rv0), 64'd0);
    check("rst_rdata",  64'(rd0), 64'd0);

    // Release reset. The edges that follow are numbered 1, 2, ...
    tick();
    reset = 1'b0;
    for (int n = 1; n <= 13; n++) begin
      tick();
      if (n == 10) din = 4'h1;
      @(negedge clk);
      if (n == 3)  check("ctr_hold_e3", c0, 64'd0);
      if (n == 4)  check("ctr_first_e4", c0, 64'd1);
      if (n == 10) check("u1_pass_e10", 64'(d1), 64'd1);
      if (n == 12) check("data_low_e12", 64'(d0), 64'd0);
      if (n == 13) begin
        check("ctr_e13",      c0,       64'd10);
        check("data_rise_e13", 64'(d0), 64'd1);
        check("u1_ctr_e13",   64'(c1),  64'd13);
      end
    end

    // GPIO write and read-back
    req(1'b1, 1'b1, 3'd0, 32'h3);
    @(negedge clk);
    check("gpio_wr",     64'(g0),  64'd3);
    check("gpio_wr_nrv", 64'(rv0), 64'd0);
    gpio_in = 2'b10;
    req(1'b1, 1'b0, 3'd0, 32'h0);
    @(negedge clk);
    check("gpio_rd_rv",   64'(rv0), 64'd1);
    check("gpio_rd_out",  64'(rd0), 64'd3);
    check("gpio_rd_in",   64'(rd1), 64'd2);
    tick();
    @(negedge clk);
    check("rv_drop",    64'(rv0), 64'd0);
    check("rdata_hold", 64'(rd0), 64'd3);

    // Clear while the count is 50
    guard = 0;
    while (m_ctr[0] != 64'd50 && guard < 200) begin
      tick();
      guard++;
    end
    check("ctr50_reached", 64'(c0), 64'd50);
    req(1'b1, 1'b1, 3'd4, 32'h1);
    @(negedge clk);
    check("clr_zero", c0, 64'd0);
    tick();
    @(negedge clk);
    check("clr_then_one", c0, 64'd1);

    // Reset mid-run together with a clear, then together with a read
    reset = 1'b1;
    req(1'b1, 1'b1, 3'd4, 32'h1);
    @(negedge clk);
    check("mid_rst_ctr",   c0,      64'd0);
    check("mid_rst_gpio0", 64'(g0), 64'd0);
    check("mid_rst_gpio1", 64'(g1), 64'd1);
    check("mid_rst_data",  64'(d0), 64'd0);
    req(1'b1, 1'b0, 3'd0, 32'h0);
    @(negedge clk);
    check("mid_rst_rv",    64'(rv0), 64'd0);
    check("mid_rst_rdata", 64'(rd0), 64'd0);
    reset = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      tick();
      @(negedge clk);
      if (n == 3) check("rehold_e3", c0, 64'd0);
      if (n == 4) check("rehold_e4", c0, 64'd1);
    end

    // Snapshot across the 32-bit boundary
    tick();
    force u_dut.ctr_r = 64'h0000_0001_FFFF_FFFF;
    m_ctr[0] = 64'h0000_0001_FFFF_FFFF;
    v = 1'b1; we = 1'b0; addr = 3'd2;
    #1 release u_dut.ctr_r;
    @(posedge clk); #1;
    addr = 3'd3;
    @(negedge clk);
    check("snap_lo", 64'(rd0), 64'h0000_0000_FFFF_FFFF);
    @(posedge clk); #1;
    v = 1'b0; addr = '0;
    @(negedge clk);
    check("snap_hi", 64'(rd0), 64'd1);
    check("snap_ctr_moved", c0, 64'h0000_0002_0000_0001);

    // 64-bit wrap
    tick();
    force u_dut.ctr_r = '1;
    m_ctr[0] = '1;
    #1 release u_dut.ctr_r;
    tick();
    @(negedge clk);
    check("wrap64", c0, 64'd0);

    // 4-bit wrap on instance 1
    guard = 0;
    while (m_ctr[1] != 64'd15 && guard < 40) begin
      tick();
      guard++;
    end
    check("u1_at15", 64'(c1), 64'd15);
    tick();
    @(negedge clk);
    check("wrap4", 64'(c1), 64'd0);

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      tick();
      reset   = ($urandom_range(0, 49) == 0);
      v       = 1'($urandom);
      we      = 1'($urandom);
      addr    = 3'($urandom_range(0, 7));
      wdata   = $urandom;
      din     = 4'($urandom);
      gpio_in = 2'($urandom);
    end
    tick();
    reset = 1'b0; v = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    repeat (4) tick();
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
